pm_sort_ctrl: RTL and testbench

- Per-bit path-metric update and list-pruning controller for the L=4 SC-List polar decoder.
- Accepts the current list's path metrics (PMs) and per-path decision LLRs for one decoded bit, then builds the 2L candidate PMs.
- Drives the shared 4-path sorter (Sorter4, instantiated inside) and registers the L survivors with parent index and bit decision.
- Sits between the SC LLR engine and the path-memory/pointer-copy logic; tracks active-path count and frame bit position.

---
 rtl/pm_sort_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pm_sort_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pm_sort_ctrl.sv
// pm_sort_ctrl: per-bit path-metric update and L=4 list pruning for an SC-List polar decoder.
// Builds 2L candidate metrics, keeps the L best via sorter4, and tracks active paths and bit position.

module sorter4 #(
    parameter int PM_WIDTH    = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic [7:0][PM_WIDTH-1:0]    cand,
    output logic [3:0][PM_WIDTH-1:0]    sel_pm,
    output logic [3:0][INDEX_WIDTH-1:0] sel_idx
);
    logic [7:0][INDEX_WIDTH-1:0] rank;

    // Ties resolve toward the lower index, so ranks form a permutation of 0..7.
    always_comb begin
        rank    = '0;
        sel_pm  = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                if (j != i && (cand[j] < cand[i] || (cand[j] == cand[i] && j < i))) begin
                    rank[i] = rank[i] + INDEX_WIDTH'(1);
                end
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (rank[i] == INDEX_WIDTH'(k)) begin
                    sel_pm[k]  = cand[i];
                    sel_idx[k] = INDEX_WIDTH'(i);
                end
            end
        end
    end
endmodule

module pm_sort_ctrl #(
    parameter int PM_WIDTH    = 8,
    parameter int LLR_WIDTH   = 6,
    parameter int INDEX_WIDTH = 3,
    parameter int N_BITS      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_start,
    input  logic                  in_frozen,
    input  logic [PM_WIDTH*4-1:0] pm_in,
    input  logic [LLR_WIDTH*4-1:0] llr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PM_WIDTH*4-1:0] out_pm,
    output logic [7:0]            out_parent,
    output logic [3:0]            out_bit,
    output logic [3:0]            out_mask,
    output logic                  out_last
);
    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [PM_WIDTH-1:0] SENTINEL = '1;
    localparam logic [PM_WIDTH-1:0] SAT_MAX  = SENTINEL - PM_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, SORT, HOLD} state_t;

    state_t                        state_q, state_d;
    logic [2:0]                    n_active_q, n_active_d;
    logic [CW-1:0]                 bit_cnt_q, bit_cnt_d;
    logic [3:0][PM_WIDTH-1:0]      pm_q, pm_d;
    logic [3:0][LLR_WIDTH-1:0]     llr_q, llr_d;
    logic                          frozen_q, frozen_d;
    logic [2:0]                    n_eff_q, n_eff_d;
    logic                          last_q, last_d;
    logic [7:0][PM_WIDTH-1:0]      cand_q, cand_d;
    logic [3:0][PM_WIDTH-1:0]      out_pm_q, out_pm_d;
    logic [3:0][1:0]               out_parent_q, out_parent_d;
    logic [3:0]                    out_bit_q, out_bit_d;
    logic [3:0]                    out_mask_q, out_mask_d;
    logic                          out_last_q, out_last_d;
    logic                          out_valid_q, out_valid_d;

    logic [2:0]                    n_eff;
    logic [CW-1:0]                 bit_idx;
    logic [3:0]                    h;
    logic [3:0][LLR_WIDTH-1:0]     mag;
    logic [3:0][PM_WIDTH:0]        sum;
    logic [7:0][PM_WIDTH-1:0]      cand_c;
    logic [2:0]                    info_lim;
    logic [3:0][PM_WIDTH-1:0]      sel_pm;
    logic [3:0][INDEX_WIDTH-1:0]   sel_idx;

    sorter4 #(
        .PM_WIDTH   (PM_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_sorter (
        .cand   (cand_q),
        .sel_pm (sel_pm),
        .sel_idx(sel_idx)
    );

    always_comb begin
        state_d      = state_q;
        n_active_d   = n_active_q;
        bit_cnt_d    = bit_cnt_q;
        pm_d         = pm_q;
        llr_d        = llr_q;
        frozen_d     = frozen_q;
        n_eff_d      = n_eff_q;
        last_d       = last_q;
        cand_d       = cand_q;
        out_pm_d     = out_pm_q;
        out_parent_d = out_parent_q;
        out_bit_d    = out_bit_q;
        out_mask_d   = out_mask_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;

        in_ready = (state_q == IDLE);
        n_eff    = in_start ? 3'd1 : n_active_q;
        bit_idx  = in_start ? '0 : bit_cnt_q;
        info_lim = (n_eff_q == 3'd1) ? 3'd2 : 3'd4;

        // Inactive paths get the sentinel on both candidates so they always sort last.
        for (int unsigned l = 0; l < 4; l++) begin
            h[l]   = llr_q[l][LLR_WIDTH-1];
            mag[l] = h[l] ? (~llr_q[l] + LLR_WIDTH'(1)) : llr_q[l];
            sum[l] = {1'b0, pm_q[l]} + (PM_WIDTH+1)'(mag[l]);
            if (3'(l) < n_eff_q) begin
                cand_c[2*l]   = pm_q[l];
                cand_c[2*l+1] = (sum[l] > {1'b0, SAT_MAX}) ? SAT_MAX : sum[l][PM_WIDTH-1:0];
            end else begin
                cand_c[2*l]   = SENTINEL;
                cand_c[2*l+1] = SENTINEL;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    for (int unsigned l = 0; l < 4; l++) begin
                        pm_d[l]  = pm_in[(3-l)*PM_WIDTH +: PM_WIDTH];
                        llr_d[l] = llr_in[(3-l)*LLR_WIDTH +: LLR_WIDTH];
                    end
                    frozen_d   = in_frozen;
                    n_eff_d    = n_eff;
                    last_d     = (bit_idx == CW'(N_BITS - 1));
                    bit_cnt_d  = in_start ? CW'(1) :
                                 (bit_cnt_q == CW'(N_BITS)) ? bit_cnt_q : bit_cnt_q + CW'(1);
                    n_active_d = in_frozen ? n_eff : ((n_eff == 3'd1) ? 3'd2 : 3'd4);
                end
            end
            CALC: begin
                cand_d  = cand_c;
                state_d = SORT;
            end
            SORT: begin
                out_valid_d = 1'b1;
                out_last_d  = last_q;
                state_d     = HOLD;
                for (int unsigned k = 0; k < 4; k++) begin
                    if (frozen_q) begin
                        out_pm_d[k]     = h[k] ? cand_q[2*k+1] : cand_q[2*k];
                        out_parent_d[k] = 2'(k);
                        out_bit_d[k]    = 1'b0;
                        out_mask_d[k]   = (3'(k) < n_eff_q);
                    end else begin
                        out_pm_d[k]     = sel_pm[k];
                        out_parent_d[k] = sel_idx[k][2:1];
                        out_bit_d[k]    = h[sel_idx[k][2:1]] ^ sel_idx[k][0];
                        out_mask_d[k]   = (3'(k) < info_lim);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_pm     = '0;
        out_parent = '0;
        out_bit    = '0;
        out_mask   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            out_pm[(3-k)*PM_WIDTH +: PM_WIDTH] = out_pm_q[k];
            out_parent[(3-k)*2 +: 2]           = out_parent_q[k];
            out_bit[3-k]                       = out_bit_q[k];
            out_mask[3-k]                      = out_mask_q[k];
        end
        out_last  = out_last_q;
        out_valid = out_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_active_q   <= 3'd1;
            bit_cnt_q    <= '0;
            pm_q         <= '0;
            llr_q        <= '0;
            frozen_q     <= 1'b0;
            n_eff_q      <= 3'd1;
            last_q       <= 1'b0;
            cand_q       <= '0;
            out_pm_q     <= '0;
            out_parent_q <= '0;
            out_bit_q    <= '0;
            out_mask_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_active_q   <= n_active_d;
            bit_cnt_q    <= bit_cnt_d;
            pm_q         <= pm_d;
            llr_q        <= llr_d;
            frozen_q     <= frozen_d;
            n_eff_q      <= n_eff_d;
            last_q       <= last_d;
            cand_q       <= cand_d;
            out_pm_q     <= out_pm_d;
            out_parent_q <= out_parent_d;
            out_bit_q    <= out_bit_d;
            out_mask_q   <= out_mask_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_pm_sort_ctrl.sv
// Scoreboard bench for pm_sort_ctrl: directed bits push expected survivors, a monitor pops on handshake.
`timescale 1ns/1ps

module tb_pm_sort_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_start, in_frozen;
    logic [31:0] pm_in;
    logic [23:0] llr_in;
    logic        out_valid, out_ready;
    logic [31:0] out_pm;
    logic [7:0]  out_parent;
    logic [3:0]  out_bit, out_mask;
    logic        out_last;

    typedef struct packed {
        logic [31:0] pm;
        logic [7:0]  par;
        logic [3:0]  b;
        logic [3:0]  mask;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;

    pm_sort_ctrl #(
        .PM_WIDTH   (8),
        .LLR_WIDTH  (6),
        .INDEX_WIDTH(3),
        .N_BITS     (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_start  (in_start),
        .in_frozen (in_frozen),
        .pm_in     (pm_in),
        .llr_in    (llr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pm    (out_pm),
        .out_parent(out_parent),
        .out_bit   (out_bit),
        .out_mask  (out_mask),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] par_mask(input logic [3:0] m);
        logic [7:0] r;
        for (int k = 0; k < 4; k++) r[2*k +: 2] = {2{m[k]}};
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_pm", out_pm, e.pm);
                chk("out_parent", 32'(out_parent & par_mask(e.mask)), 32'(e.par & par_mask(e.mask)));
                chk("out_bit", 32'(out_bit & e.mask), 32'(e.b & e.mask));
                chk("out_mask", 32'(out_mask), 32'(e.mask));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic send(input logic st, input logic fz, input logic [31:0] pm, input logic [23:0] llr,
                        input logic [31:0] epm, input logic [7:0] epar, input logic [3:0] eb,
                        input logic [3:0] emask, input logic push);
        int   idx;
        logic accepted;
        exp_t e;
        if (st) begin
            idx = 0; cnt_m = 1;
        end else begin
            idx = cnt_m; cnt_m = (cnt_m == 64) ? 64 : cnt_m + 1;
        end
        e.pm = epm; e.par = epar; e.b = eb; e.mask = emask; e.last = (idx == 63);
        if (push) q.push_back(e);
        @(posedge clk); #1;
        in_start = st; in_frozen = fz; pm_in = pm; llr_in = llr; in_valid = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        chk("sb_drain", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_pm;
        logic [31:0] snap_ctl;
        rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_frozen = 1'b0;
        pm_in = '0; llr_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_mask", 32'(out_mask), 32'd0);
        chk("reset_out_pm", out_pm, 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);

        // Frozen start bit, llr0 = -5, with latency check.
        send(1, 1, 32'h0, {6'h3B, 18'h0}, {8'd5, 8'hFF, 8'hFF, 8'hFF}, 8'h1B, 4'b0000, 4'b1000, 1);
        @(negedge clk);
        chk("lat_edge0_valid", 32'(out_valid), 32'd0);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);

        // Info bits growing the list 1 -> 2 -> 4.
        send(0, 0, {8'd10, 24'h0}, {6'h03, 18'h0}, {8'd10, 8'd13, 8'hFF, 8'hFF}, 8'h00, 4'b0100, 4'b1100, 1);
        send(0, 0, {8'd10, 8'd13, 16'h0}, {6'h3C, 6'h14, 12'h0}, {8'd10, 8'd13, 8'd14, 8'd33},
             8'h11, 4'b1001, 4'b1111, 1);
        // Saturation: 250 + 32 clamps to 254.
        send(1, 0, {8'd250, 24'h0}, {6'h20, 18'h0}, {8'd250, 8'd254, 8'hFF, 8'hFF}, 8'h00, 4'b1000, 4'b1100, 1);
        // Frozen bit with two active paths.
        send(0, 1, {8'd3, 8'd7, 16'h0}, {6'h06, 6'h3E, 12'h0}, {8'd3, 8'd9, 8'hFF, 8'hFF}, 8'h1B, 4'b0000, 4'b1100, 1);
        drain();

        // Reset while holding a result.
        @(posedge clk); #1 out_ready = 1'b0;
        send(0, 0, {8'd1, 8'd2, 16'h0}, {6'h01, 6'h02, 12'h0}, '0, '0, '0, '0, 0);
        wait_valid("rst_pre_valid");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt_m = 0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_mask", 32'(out_mask), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        // Non-start info bit right after reset must see n_active = 1.
        send(0, 0, {8'd20, 24'h0}, {6'h3F, 18'h0}, {8'd20, 8'd21, 8'hFF, 8'hFF}, 8'h00, 4'b1000, 4'b1100, 1);

        while (cnt_m < 63)
            send(0, 1, 32'h0, 24'h0, {8'd0, 8'd0, 8'hFF, 8'hFF}, 8'h1B, 4'b0000, 4'b1100, 1);
        drain();

        // Bit 63 under backpressure.
        @(posedge clk); #1 out_ready = 1'b0;
        send(0, 1, 32'h0, 24'h0, {8'd0, 8'd0, 8'hFF, 8'hFF}, 8'h1B, 4'b0000, 4'b1100, 1);
        wait_valid("bp_valid");
        chk("last_flag_bit63", 32'(out_last), 32'd1);
        snap_pm  = out_pm;
        snap_ctl = {13'h0, out_parent, out_bit, out_mask, out_last, out_valid, in_ready};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_stable_pm", out_pm, snap_pm);
            chk("bp_stable_ctl", {13'h0, out_parent, out_bit, out_mask, out_last, out_valid, in_ready}, snap_ctl);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;

        // Past end of frame, then a new frame start.
        send(0, 1, 32'h0, 24'h0, {8'd0, 8'd0, 8'hFF, 8'hFF}, 8'h1B, 4'b0000, 4'b1100, 1);
        send(1, 1, 32'h0, {6'h3B, 18'h0}, {8'd5, 8'hFF, 8'hFF, 8'hFF}, 8'h1B, 4'b0000, 4'b1000, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
